// File: rtl/i2c_eeprom_page_writer.sv
// I2C EEPROM page writer: streams buffer words to a 24xx-style EEPROM in page-sized
// bursts, ACK-polls after every STOP, and reports NACK or poll-timeout errors.
module i2c_eeprom_page_writer #(
  parameter int unsigned CLK_DIV    = 256,
  parameter int unsigned ADDR_SZ    = 10,
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned PAGE_BYTES = 32,
  parameter int unsigned ADDR_BYTES = 2,
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned MAX_POLL   = 255
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [ADDR_SZ-1:0]      i_mem_offset,
  input  logic [ADDR_SZ-1:0]      i_word_len,
  output logic                    o_rd_en,
  output logic [ADDR_SZ-1:0]      o_rd_addr,
  input  logic [8*WORD_BYTES-1:0] i_rd_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [1:0]              o_err_code,
  output logic                    o_scl,
  output logic                    o_sda_oe,
  input  logic                    i_sda
);

  localparam int unsigned BA_W = ADDR_SZ + 2;
  localparam int unsigned DW   = 8 * WORD_BYTES;
  localparam int unsigned PH_W = $clog2(CLK_DIV);
  localparam int unsigned PL_W = $clog2(MAX_POLL + 1);
  localparam logic [PH_W-1:0] PH_Q1  = PH_W'(CLK_DIV / 4);
  localparam logic [PH_W-1:0] PH_H   = PH_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0] PH_Q3  = PH_W'(3 * CLK_DIV / 4);
  localparam logic [PH_W-1:0] PH_END = PH_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, DEV, MADDR, FETCH, DATA, STOP,
    POLL_START, POLL_DEV, POLL_STOP, DONE, ERR
  } state_t;

  state_t              r_state, w_nxt;
  logic [PH_W-1:0]     r_phase;
  logic [3:0]          r_bit;
  logic [1:0]          r_bidx;
  logic [1:0]          r_fstep;
  logic [ADDR_SZ-1:0]  r_offset, r_len, r_sent;
  logic [DW-1:0]       r_word;
  logic [PL_W-1:0]     r_poll;
  logic                r_nack, r_err_pend;
  logic                r_scl, r_sda_oe, r_rd_en, r_busy, r_done, r_err;
  logic [ADDR_SZ-1:0]  r_rd_addr;
  logic [1:0]          r_err_code;

  logic                w_scl, w_oe;
  logic                w_slot_state, w_byte_state, w_slot_end, w_byte_end;
  logic                w_scl_bit, w_bit_oe, w_last_byte, w_last_word, w_page_end;
  logic [ADDR_SZ-1:0]  w_sent_inc;
  logic [BA_W-1:0]     w_baddr, w_baddr_inc;
  logic [31:0]         w_baddr32, w_word32;
  logic [1:0]          w_ma_sh, w_dt_sh;
  logic [7:0]          w_tx_byte;

  // Slot timing and byte-address arithmetic
  assign w_byte_state = (r_state == DEV) || (r_state == MADDR) ||
                        (r_state == DATA) || (r_state == POLL_DEV);
  assign w_slot_state = w_byte_state || (r_state == START) || (r_state == STOP) ||
                        (r_state == POLL_START) || (r_state == POLL_STOP);
  assign w_slot_end   = (r_phase == PH_END);
  assign w_byte_end   = w_slot_end && (r_bit == 4'd8);
  assign w_scl_bit    = (r_phase >= PH_Q1) && (r_phase < PH_Q3);

  assign w_sent_inc  = r_sent + ADDR_SZ'(1);
  assign w_baddr     = BA_W'((BA_W'(r_offset) + BA_W'(r_sent)) * BA_W'(WORD_BYTES));
  assign w_baddr_inc = BA_W'((BA_W'(r_offset) + BA_W'(w_sent_inc)) * BA_W'(WORD_BYTES));
  assign w_page_end  = (w_baddr_inc & BA_W'(PAGE_BYTES - 1)) == '0;
  assign w_last_word = (w_sent_inc == r_len);

  assign w_baddr32 = 32'(w_baddr);
  assign w_word32  = 32'(r_word);
  assign w_ma_sh   = 2'(ADDR_BYTES - 1) - r_bidx;
  assign w_dt_sh   = 2'(WORD_BYTES - 1) - r_bidx;
  assign w_last_byte = (r_state == MADDR) ? (r_bidx == 2'(ADDR_BYTES - 1))
                                          : (r_bidx == 2'(WORD_BYTES - 1));

  always_comb begin
    w_tx_byte = {DEV_ADDR, 1'b0};
    if (r_state == MADDR)     w_tx_byte = 8'(w_baddr32 >> {w_ma_sh, 3'b000});
    else if (r_state == DATA) w_tx_byte = 8'(w_word32 >> {w_dt_sh, 3'b000});
  end

  assign w_bit_oe = (r_bit < 4'd8) && !w_tx_byte[3'(4'd7 - r_bit)];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  // Next state and bus line levels
  always_comb begin
    w_nxt = r_state;
    w_scl = 1'b1;
    w_oe  = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_nxt = (i_word_len == '0) ? DONE : START;
      START, POLL_START: begin
        w_scl = (r_phase < PH_Q3);
        w_oe  = (r_phase >= PH_H);
        if (w_slot_end) w_nxt = (r_state == START) ? DEV : POLL_DEV;
      end
      DEV: begin
        w_scl = w_scl_bit;
        w_oe  = w_bit_oe;
        if (w_byte_end) w_nxt = r_nack ? STOP : MADDR;
      end
      MADDR: begin
        w_scl = w_scl_bit;
        w_oe  = w_bit_oe;
        if (w_byte_end) w_nxt = r_nack ? STOP : (w_last_byte ? FETCH : MADDR);
      end
      FETCH: begin
        w_scl = 1'b0;
        if (r_fstep == 2'd2) w_nxt = DATA;
      end
      DATA: begin
        w_scl = w_scl_bit;
        w_oe  = w_bit_oe;
        if (w_byte_end) begin
          if (r_nack)                          w_nxt = STOP;
          else if (!w_last_byte)               w_nxt = DATA;
          else if (w_last_word || w_page_end)  w_nxt = STOP;
          else                                 w_nxt = FETCH;
        end
      end
      POLL_DEV: begin
        w_scl = w_scl_bit;
        w_oe  = w_bit_oe;
        if (w_byte_end) w_nxt = r_nack ? POLL_STOP : ((r_sent == r_len) ? DONE : START);
      end
      STOP: begin
        w_scl = (r_phase >= PH_Q1);
        w_oe  = (r_phase < PH_H);
        if (w_slot_end) w_nxt = r_err_pend ? ERR : POLL_START;
      end
      POLL_STOP: begin
        w_scl = (r_phase >= PH_Q1);
        w_oe  = (r_phase < PH_H);
        if (w_slot_end) w_nxt = (r_poll == PL_W'(MAX_POLL)) ? ERR : POLL_START;
      end
      DONE, ERR: w_nxt = IDLE;
      default:   w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase    <= '0;
      r_bit      <= '0;
      r_bidx     <= '0;
      r_fstep    <= '0;
      r_offset   <= '0;
      r_len      <= '0;
      r_sent     <= '0;
      r_word     <= '0;
      r_poll     <= '0;
      r_nack     <= 1'b0;
      r_err_pend <= 1'b0;
      r_scl      <= 1'b1;
      r_sda_oe   <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_scl    <= w_scl;
      r_sda_oe <= w_oe;
      r_busy   <= (w_nxt != IDLE);
      r_done   <= (w_nxt == DONE);
      r_err    <= (w_nxt == ERR);

      r_phase <= (w_slot_state && !w_slot_end) ? r_phase + PH_W'(1) : '0;

      if (!w_byte_state)   r_bit <= '0;
      else if (w_slot_end) r_bit <= (r_bit == 4'd8) ? 4'd0 : r_bit + 4'd1;

      if ((r_state != MADDR) && (r_state != DATA)) r_bidx <= '0;
      else if (w_byte_end) r_bidx <= (w_nxt == r_state) ? r_bidx + 2'd1 : 2'd0;

      if (w_byte_state && (r_bit == 4'd8) && (r_phase == PH_H)) r_nack <= i_sda;

      if ((r_state == IDLE) && i_start) begin
        r_offset   <= i_mem_offset;
        r_len      <= i_word_len;
        r_sent     <= '0;
        r_poll     <= '0;
        r_err_pend <= 1'b0;
        r_err_code <= 2'b00;
      end

      // Byte NACK aborts the burst through a STOP into ERR
      if (w_byte_end && r_nack && ((r_state == DEV) || (r_state == MADDR) || (r_state == DATA)))
        r_err_pend <= 1'b1;
      if ((r_state == DATA) && w_byte_end && !r_nack && w_last_byte) r_sent <= w_sent_inc;

      if ((r_state == STOP) && w_slot_end) r_poll <= '0;
      if ((r_state == POLL_DEV) && w_byte_end && r_nack) r_poll <= r_poll + PL_W'(1);

      if ((w_nxt == ERR) && (r_state != ERR))
        r_err_code <= (r_state == POLL_STOP) ? 2'b10 : 2'b01;

      // Buffer read: strobe, wait for the synchronous read, then capture
      if (r_state == FETCH) begin
        case (r_fstep)
          2'd0: begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_sent;
            r_fstep   <= 2'd1;
          end
          2'd1: begin
            r_rd_en <= 1'b0;
            r_fstep <= 2'd2;
          end
          default: begin
            r_word  <= i_rd_data;
            r_fstep <= 2'd0;
          end
        endcase
      end else begin
        r_fstep <= 2'd0;
        r_rd_en <= 1'b0;
      end
    end
  end

  assign o_scl      = r_scl;
  assign o_sda_oe   = r_sda_oe;
  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_i2c_eeprom_page_writer.sv
// Directed bench: open-drain bus with a behavioural EEPROM slave (ACK/NACK policies,
// write-cycle ACK polling) and a synchronous word buffer feeding two writer instances.
module tb_i2c_eeprom_page_writer;

  localparam int unsigned CD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        st0 = 1'b0, st1 = 1'b0;
  logic [9:0]  st_off = '0, st_len = '0;
  logic        rd_en0, rd_en1, busy0, busy1, done0, done1, err0, err1;
  logic [9:0]  rd_addr0, rd_addr1;
  logic [15:0] rdd0 = '0, rdd1 = '0;
  logic [1:0]  code0, code1;
  logic        scl0, scl1, oe0, oe1, sda0, sda1;
  logic        sel = 1'b0;
  logic        pull = 1'b0;
  logic [15:0] mem [0:3];

  assign sda0 = ~(oe0 | (pull & ~sel));
  assign sda1 = ~(oe1 | (pull & sel));

  i2c_eeprom_page_writer #(.CLK_DIV(CD)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(st0), .i_mem_offset(st_off), .i_word_len(st_len),
    .o_rd_en(rd_en0), .o_rd_addr(rd_addr0), .i_rd_data(rdd0), .o_busy(busy0),
    .o_done(done0), .o_err(err0), .o_err_code(code0), .o_scl(scl0), .o_sda_oe(oe0),
    .i_sda(sda0));

  i2c_eeprom_page_writer #(.CLK_DIV(CD), .MAX_POLL(4)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(st1), .i_mem_offset(st_off), .i_word_len(st_len),
    .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_rd_data(rdd1), .o_busy(busy1),
    .o_done(done1), .o_err(err1), .o_err_code(code1), .o_scl(scl1), .o_sda_oe(oe1),
    .i_sda(sda1));

  always @(posedge clk) begin
    if (rd_en0) rdd0 <= mem[rd_addr0[1:0]];
    if (rd_en1) rdd1 <= mem[rd_addr1[1:0]];
  end

  int n_tot = 0, n_bad = 0;
  int n_start, n_stop, n_poll, n_done, n_err, bitcnt, fbyte, poll_left, nack_at;
  bit wc, prev_scl, prev_sda, s_scl, s_sda;
  logic [7:0] sh;
  logic [7:0] rx_q[$];
  int rd_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    @(posedge clk);
    rx_q.delete(); rd_q.delete();
    n_start = 0; n_stop = 0; n_poll = 0; n_done = 0; n_err = 0;
    bitcnt = 0; fbyte = 0; wc = 1'b0; pull = 1'b0; sh = '0;
    poll_left = 0; nack_at = -1; prev_scl = 1'b1; prev_sda = 1'b1;
  endtask

  // Bus monitor and EEPROM slave, evaluated away from the DUT clock edge
  always @(negedge clk) begin
    s_scl = sel ? scl1 : scl0;
    s_sda = ~((sel ? oe1 : oe0) | pull);
    if (sel ? done1 : done0) n_done++;
    if (sel ? err1 : err0) n_err++;
    if (sel ? rd_en1 : rd_en0) rd_q.push_back(int'(sel ? rd_addr1 : rd_addr0));
    if (prev_scl && s_scl && prev_sda && !s_sda) begin
      n_start++; bitcnt = 0; fbyte = 0;
    end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
      n_stop++; bitcnt = 0;
      if (fbyte > 1) wc = 1'b1;
    end else if (!prev_scl && s_scl) begin
      if (bitcnt < 8) sh = {sh[6:0], s_sda};
      bitcnt++;
    end else if (prev_scl && !s_scl) begin
      if (bitcnt == 8) begin
        rx_q.push_back(sh);
        if (wc && fbyte == 0) begin
          n_poll++;
          if (poll_left != 0) begin
            if (poll_left > 0) poll_left--;
            pull = 1'b0;
          end else begin
            pull = 1'b1; wc = 1'b0;
          end
        end else begin
          pull = (fbyte != nack_at);
        end
      end else if (bitcnt == 9) begin
        pull = 1'b0; bitcnt = 0; fbyte++;
      end
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  task automatic xfer(input string tag, input logic [9:0] off, input logic [9:0] len,
                      input int maxc);
    int base;
    base = n_done + n_err;
    @(negedge clk);
    st_off = off; st_len = len;
    if (sel) st1 = 1'b1; else st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0; st1 = 1'b0;
    for (int i = 0; i < maxc && (n_done + n_err) == base; i++) @(negedge clk);
    chk({tag, "_end"}, n_done + n_err - base, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] exp[$]);
    chk({tag, "_nbytes"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), rx_q[i], exp[i]);
  endtask

  initial begin
    logic [7:0] e[$];
    bit found;
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;
    mreset();
    repeat (3) @(negedge clk);
    chk("rst_scl", scl0, 1); chk("rst_oe", oe0, 0); chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0); chk("rst_err", err0, 0); chk("rst_code", code0, 0);
    chk("rst_rden", rd_en0, 0); chk("rst_rdaddr", rd_addr0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Zero-length request: done one cycle after acceptance, bus untouched
    mreset();
    @(negedge clk);
    st_len = '0; st_off = 10'd5; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    chk("len0_done", done0, 1); chk("len0_busy", busy0, 1);
    @(negedge clk);
    chk("len0_done_off", done0, 0); chk("len0_idle", busy0, 0);
    repeat (4) @(negedge clk);
    chk("len0_nstart", n_start, 0); chk("len0_scl", scl0, 1);

    // Three words inside one page
    mreset();
    xfer("s1", 10'd0, 10'd3, 6000);
    e = '{8'hA0, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hA0};
    chk_bytes("s1", e);
    chk("s1_nstop", n_stop, 1); chk("s1_nstart", n_start, 2);
    chk("s1_nrd", rd_q.size(), 3);
    for (int i = 0; i < 3 && i < rd_q.size(); i++) chk($sformatf("s1_rd%0d", i), rd_q[i], i);
    chk("s1_ndone", n_done, 1); chk("s1_nerr", n_err, 0);

    // Page boundary split at byte address 0x20
    mreset();
    xfer("s2", 10'd14, 10'd4, 8000);
    e = '{8'hA0, 8'h00, 8'h1C, 8'h12, 8'h34, 8'h56, 8'h78, 8'hA0,
          8'hA0, 8'h00, 8'h20, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hA0};
    chk_bytes("s2", e);
    chk("s2_nstop", n_stop, 2); chk("s2_ndone", n_done, 1); chk("s2_nrd", rd_q.size(), 4);

    // Five poll NACKs, then ACK
    mreset();
    poll_left = 5;
    xfer("s3", 10'd0, 10'd1, 8000);
    chk("s3_npoll", n_poll, 6); chk("s3_ndone", n_done, 1); chk("s3_nerr", n_err, 0);

    // NACK on the second data byte
    mreset();
    nack_at = 4;
    xfer("s5", 10'd0, 10'd3, 6000);
    chk("s5_nbytes", rx_q.size(), 5); chk("s5_nstop", n_stop, 1);
    chk("s5_nstart", n_start, 1); chk("s5_nrd", rd_q.size(), 1);
    chk("s5_nerr", n_err, 1); chk("s5_code", code0, 2'b01); chk("s5_ndone", n_done, 0);

    // Asynchronous reset in the middle of DATA releases the bus immediately
    mreset();
    @(negedge clk);
    st_off = '0; st_len = 10'd3; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (rx_q.size() >= 4 && !scl0 && oe0) found = 1'b1;
    end
    chk("s6_middata", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("s6_scl", scl0, 1); chk("s6_oe", oe0, 0); chk("s6_busy", busy0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mreset();
    xfer("s6", 10'd0, 10'd1, 4000);
    e = '{8'hA0, 8'h00, 8'h00, 8'h12, 8'h34, 8'hA0};
    chk_bytes("s6", e);
    chk("s6_ndone", n_done, 1); chk("s6_nerr", n_err, 0);

    // Poll timeout on the MAX_POLL=4 instance
    sel = 1'b1;
    mreset();
    poll_left = -1;
    xfer("s4", 10'd0, 10'd1, 6000);
    chk("s4_npoll", n_poll, 4); chk("s4_nerr", n_err, 1); chk("s4_ndone", n_done, 0);
    chk("s4_code", code1, 2'b10); chk("s4_idle", busy1, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_page_writer.md
I2C_EEPROM_PAGE_WRITER -- requirements
Module: i2c_eeprom_page_writer

Interface
REQ-001 The block SHALL have these parameters:
- CLK_DIV, 256: i_clk cycles per SCL bit; multiple of 4, minimum 16.
- ADDR_SZ, 10: width of the word offset and the word count.
- WORD_BYTES, 2: bytes per buffer word, 1..4.
- PAGE_BYTES, 32: EEPROM page size; a power of 2 and a multiple of WORD_BYTES.
- ADDR_BYTES, 2: EEPROM memory-address bytes, 1 or 2.
- DEV_ADDR, 7'h50: 7-bit I2C device address.
- MAX_POLL, 255: maximum number of ACK-poll attempts after each page.

REQ-002 The block SHALL have these ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset.
- i_start, in, 1: request pulse.
- i_mem_offset, in, ADDR_SZ: first EEPROM word.
- i_word_len, in, ADDR_SZ: number of words to write.
- o_rd_en, out, 1: buffer read strobe.
- o_rd_addr, out, ADDR_SZ: buffer word index, starting at 0.
- i_rd_data, in, 8*WORD_BYTES: buffer word.
- o_busy, out, 1: a request is in progress.
- o_done, out, 1: one-cycle success pulse.
- o_err, out, 1: one-cycle failure pulse.
- o_err_code, out, 2: 01 = data or address NACK, 10 = poll timeout.
- o_scl, out, 1: SCL.
- o_sda_oe, out, 1: drives SDA low when 1.
- i_sda, in, 1: SDA input.

REQ-003 There SHALL be one clock. Reset is asynchronous and active-high.

Function
REQ-004 i_start SHALL be accepted only in IDLE. It is ignored while o_busy=1. i_mem_offset and i_word_len SHALL be latched on acceptance.

REQ-005 If i_word_len=0, the block SHALL pulse o_done one cycle after acceptance, with no bus activity.

REQ-006 The FSM states SHALL be IDLE, START, DEV, MADDR, FETCH, DATA, STOP, POLL_START, POLL_DEV, POLL_STOP, DONE and ERR.

REQ-007 The bit slot SHALL be CLK_DIV cycles long:
- SDA changes at phase 0.
- SCL is high from CLK_DIV/4 to 3*CLK_DIV/4-1.
- ACK is sampled from i_sda at phase CLK_DIV/2 of the 9th bit.
- o_sda_oe=0 during the ACK bit.

REQ-008 START and STOP timing:
- START: SDA falls while SCL is high, CLK_DIV/2 cycles after both lines are released.
- STOP: SDA rises while SCL is high.

REQ-009 Byte address = (offset + words_sent)*WORD_BYTES, kept at ADDR_SZ+2 bits. MADDR SHALL send ADDR_BYTES bytes of it, MSB byte first.

REQ-010 DEV SHALL send {DEV_ADDR, 1'b0}. All bytes SHALL be sent MSB first.

REQ-011 FETCH SHALL pulse o_rd_en for one cycle with o_rd_addr = words_sent. i_rd_data SHALL be registered on the following cycle. DATA SHALL then send the word's WORD_BYTES bytes, most significant byte first.

REQ-012 After each word's last ACK the block SHALL choose the next state as follows:
- If words_sent = word_len, go to STOP.
- Else if the byte address is a multiple of PAGE_BYTES (page boundary), go to STOP.
- Otherwise go to FETCH.
Page writes SHALL therefore never wrap inside the EEPROM page.

REQ-013 After each STOP the block SHALL ACK-poll, replacing any fixed wait:
- POLL_START then POLL_DEV sends the device byte.
- ACK ends the poll. If words remain, go to START for the next page; otherwise go to DONE.
- NACK goes to POLL_STOP, then a retry.
- When attempts reach MAX_POLL without ACK, go to ERR with code 10.

REQ-014 A NACK on the DEV, MADDR or DATA bytes SHALL cause a STOP, then ERR with code 01.

REQ-015 DONE SHALL pulse o_done for one cycle. ERR SHALL pulse o_err for one cycle and hold o_err_code until the next accepted i_start. Both states SHALL return to IDLE.

REQ-016 o_busy SHALL be 1 from the cycle after acceptance until the return to IDLE.

REQ-017 Word counters SHALL be ADDR_SZ bits wide. Byte-address overflow beyond the ADDR_SZ+2 bit width SHALL wrap silently.

Reset
REQ-018 On i_rst the block SHALL go to IDLE and set:
- o_scl=1 and o_sda_oe=0 (bus released);
- o_rd_en, o_busy, o_done and o_err = 0;
- o_err_code=00, o_rd_addr=0;
- all counters cleared.

REQ-019 Reset asserted mid-transfer SHALL release the bus asynchronously, without generating a STOP. The first i_start after reset SHALL begin a fresh transfer.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write offset=0, len=3, ACK-all model, default parameters: device byte 0xA0, address 0x00 0x00, then 6 data bytes MSB first; one STOP; o_rd_en pulses 3 times with addresses 0,1,2; o_done pulses once after the first poll ACK.
- Write offset=14, len=4: page 1 carries address 0x00 0x1C and words 0 and 1; STOP; poll; page 2 carries address 0x00 0x20 and words 2 and 3.
- EEPROM model NACKs 5 polls then ACKs: 6 poll frames seen; o_done asserted; o_err never asserted.
- Model never ACKs polls, MAX_POLL=4: exactly 4 poll frames; o_err pulses with o_err_code=10.
- NACK on the second data byte: STOP follows immediately; o_err_code=01; no further o_rd_en.
- Reset in the middle of DATA: o_scl=1 and o_sda_oe=0 in the same cycle; a subsequent i_start with len=1 completes with o_done.
